// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg
//   Shared definitions for the instruction-memory program loader.
//   - loader_state_t : loader FSM states
//   - WORD_BYTES     : bytes per MIPS instruction word
//   - BYTE_WIDTH     : bits per stream byte
//   - WORD_WIDTH     : bits per instruction word
//   Byte order: the stream is big-endian. The first byte of a word ends up
//   in bits [31:24] and the last byte in bits [7:0].
package imem_loader_pkg;

    localparam int WORD_BYTES = 4;
    localparam int BYTE_WIDTH = 8;
    localparam int WORD_WIDTH = WORD_BYTES * BYTE_WIDTH;

    // Set when the first byte of a word is the most significant one.
    localparam bit FIRST_BYTE_IS_MSB = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        WRITE,
        DONE,
        ERR
    } loader_state_t;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// byte_packer
//   Packs bytes big-endian into a 32-bit word by shifting each new byte in
//   at the least significant end.
//   Ports:
//     clk       in   clock
//     rst       in   synchronous active-low reset
//     shift_en  in   accept byte_in this cycle
//     clear     in   drop any partial word and reset the byte index
//     byte_in   in   stream byte
//     word_out  out  word as it stands after shifting in byte_in
//     full      out  byte_in is the fourth byte of the word (index==3 on shift)
module byte_packer
    import imem_loader_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  shift_en,
    input  logic                  clear,
    input  logic [BYTE_WIDTH-1:0] byte_in,
    output logic [WORD_WIDTH-1:0] word_out,
    output logic                  full
);

    // Only the three bytes that precede the final one need storing; the
    // fourth is combined directly into word_out on the cycle it arrives.
    logic [WORD_WIDTH-BYTE_WIDTH-1:0] shift_reg;
    logic [1:0]                       idx_reg;
    logic [WORD_WIDTH-1:0]            shifted;

    genvar gi;
    generate
        for (gi = 0; gi < WORD_BYTES; gi++) begin : g_lane
            if (gi == 0) begin : g_new
                assign shifted[BYTE_WIDTH-1:0] = byte_in;
            end else begin : g_old
                assign shifted[gi*BYTE_WIDTH +: BYTE_WIDTH] =
                    shift_reg[(gi-1)*BYTE_WIDTH +: BYTE_WIDTH];
            end
        end
    endgenerate

    assign word_out = shifted;
    assign full     = shift_en && (idx_reg == 2'(WORD_BYTES - 1));

    always_ff @(posedge clk) begin
        if (!rst || clear) begin
            shift_reg <= '0;
            idx_reg   <= '0;
        end else if (shift_en) begin
            shift_reg <= shifted[WORD_WIDTH-BYTE_WIDTH-1:0];
            idx_reg   <= idx_reg + 2'd1;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// imem_loader
//   Streams a program into instruction memory and holds the CPU in reset
//   until a complete program has been written.
//   Ports:
//     clk, rst         clock; synchronous active-low reset
//     start            one-cycle pulse, begins a load at word 0
//     in_valid/ready   byte stream handshake; in_data byte, in_last final byte
//     mem_we/addr/wdata  one-cycle instruction-memory write per word
//     cpu_hold         high keeps the datapath in reset
//     done / error     level status of the last load
//     word_count       words written by the current or last load
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [BYTE_WIDTH-1:0] in_data,
    input  logic                  in_last,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [WORD_WIDTH-1:0] mem_wdata,
    output logic                  cpu_hold,
    output logic                  done,
    output logic                  error,
    output logic [ADDR_WIDTH:0]   word_count
);

    loader_state_t         state_reg, state_next;
    logic [ADDR_WIDTH-1:0] addr_reg;
    logic [ADDR_WIDTH:0]   count_reg;
    logic [ADDR_WIDTH:0]   count_inc;
    logic                  last_reg;
    logic [ADDR_WIDTH-1:0] mem_addr_reg;
    logic [WORD_WIDTH-1:0] mem_wdata_reg;

    logic                  pk_shift;
    logic                  pk_clear;
    logic                  pk_full;
    logic [WORD_WIDTH-1:0] pk_word;
    logic                  load_start;
    logic                  word_latch;

    // A byte transfers whenever LOAD sees in_valid (in_ready is the LOAD decode).
    assign pk_shift  = (state_reg == LOAD) && in_valid;
    assign count_inc = count_reg + 1'b1;

    byte_packer u_packer (
        .clk      (clk),
        .rst      (rst),
        .shift_en (pk_shift),
        .clear    (pk_clear),
        .byte_in  (in_data),
        .word_out (pk_word),
        .full     (pk_full)
    );

    always_comb begin
        state_next = state_reg;
        in_ready   = 1'b0;
        mem_we     = 1'b0;
        cpu_hold   = 1'b1;
        done       = 1'b0;
        error      = 1'b0;
        pk_clear   = 1'b0;
        load_start = 1'b0;
        word_latch = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next = LOAD;
                    load_start = 1'b1;
                    pk_clear   = 1'b1;
                end
            end
            LOAD: begin
                in_ready = 1'b1;
                if (pk_full) begin
                    word_latch = 1'b1;
                    state_next = WRITE;
                end else if (pk_shift && in_last) begin
                    // Program ended mid-word: drop the partial word.
                    pk_clear   = 1'b1;
                    state_next = ERR;
                end
            end
            WRITE: begin
                mem_we = 1'b1;
                if (last_reg) begin
                    state_next = DONE;
                end else if (count_inc[ADDR_WIDTH]) begin
                    // Memory is full and no in_last yet: the next write would wrap.
                    state_next = ERR;
                end else begin
                    state_next = LOAD;
                end
            end
            DONE: begin
                done     = 1'b1;
                cpu_hold = 1'b0;
                if (start) begin
                    state_next = LOAD;
                    load_start = 1'b1;
                    pk_clear   = 1'b1;
                end
            end
            ERR: begin
                error = 1'b1;
                if (start) begin
                    state_next = LOAD;
                    load_start = 1'b1;
                    pk_clear   = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg     <= IDLE;
            addr_reg      <= '0;
            count_reg     <= '0;
            last_reg      <= 1'b0;
            mem_addr_reg  <= '0;
            mem_wdata_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (load_start) begin
                addr_reg  <= '0;
                count_reg <= '0;
            end
            // Capture address and data one cycle early so both are stable
            // for the whole write cycle and held afterwards.
            if (word_latch) begin
                mem_addr_reg  <= addr_reg;
                mem_wdata_reg <= pk_word;
                last_reg      <= in_last;
            end
            if (mem_we) begin
                addr_reg  <= addr_reg + 1'b1;
                count_reg <= count_inc;
            end
        end
    end

    assign mem_addr   = mem_addr_reg;
    assign mem_wdata  = mem_wdata_reg;
    assign word_count = count_reg;

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    // main instance, ADDR_WIDTH = 8
    logic        start, in_valid, in_ready, in_last, mem_we, cpu_hold, done, error;
    logic [7:0]  in_data, mem_addr;
    logic [31:0] mem_wdata;
    logic [8:0]  word_count;
    // small instance, ADDR_WIDTH = 2
    logic        s_start, s_in_valid, s_in_ready, s_in_last, s_mem_we, s_cpu_hold, s_done, s_error;
    logic [7:0]  s_in_data;
    logic [1:0]  s_mem_addr;
    logic [31:0] s_mem_wdata;
    logic [2:0]  s_word_count;

    imem_loader #(.ADDR_WIDTH(8)) dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_last(in_last), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .cpu_hold(cpu_hold), .done(done), .error(error),
        .word_count(word_count)
    );

    imem_loader #(.ADDR_WIDTH(2)) dut_small (
        .clk(clk), .rst(rst), .start(s_start), .in_valid(s_in_valid), .in_ready(s_in_ready),
        .in_data(s_in_data), .in_last(s_in_last), .mem_we(s_mem_we), .mem_addr(s_mem_addr),
        .mem_wdata(s_mem_wdata), .cpu_hold(s_cpu_hold), .done(s_done), .error(s_error),
        .word_count(s_word_count)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always @(posedge clk) cyc++;

    // Captured writes from each instance.
    int          wr_addr_q[$];
    logic [31:0] wr_data_q[$];
    int          wr_cyc_q[$];
    int          s_wr_addr_q[$];
    logic [31:0] s_wr_data_q[$];

    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            wr_addr_q.push_back(int'(mem_addr));
            wr_data_q.push_back(mem_wdata);
            wr_cyc_q.push_back(cyc);
            $display("write main  addr=%0d data=%08h cycle=%0d", mem_addr, mem_wdata, cyc);
        end
        if (s_mem_we === 1'b1) begin
            s_wr_addr_q.push_back(int'(s_mem_addr));
            s_wr_data_q.push_back(s_mem_wdata);
            $display("write small addr=%0d data=%08h cycle=%0d", s_mem_addr, s_mem_wdata, cyc);
        end
    end

    // Reference model: stimulus stream in, expected writes and outcome out.
    logic [7:0]  stim_q[$];
    int          stim_last;
    int          exp_addr_q[$];
    logic [31:0] exp_data_q[$];
    bit          exp_done, exp_err;

    task automatic model_load(input int cap);
        int total;
        int words;
        logic [31:0] w;
        exp_addr_q.delete();
        exp_data_q.delete();
        exp_done = 0;
        exp_err  = 0;
        total = (stim_last >= 0) ? stim_last + 1 : stim_q.size();
        words = total / 4;
        for (int k = 0; k < words; k++) begin
            w = 32'(stim_q[4*k]) * 32'h0100_0000 + 32'(stim_q[4*k+1]) * 32'h0001_0000
              + 32'(stim_q[4*k+2]) * 32'h0000_0100 + 32'(stim_q[4*k+3]);
            exp_addr_q.push_back(k);
            exp_data_q.push_back(w);
            if (stim_last == 4*k + 3) begin
                exp_done = 1;
                break;
            end
            if (k + 1 == cap) begin
                exp_err = 1;
                break;
            end
        end
        if (!exp_done && !exp_err && stim_last >= 0) exp_err = 1;
    endtask

    task automatic clear_caps();
        wr_addr_q.delete();
        wr_data_q.delete();
        wr_cyc_q.delete();
        s_wr_addr_q.delete();
        s_wr_data_q.delete();
    endtask

    // All tasks start and end 1 time unit after a rising edge.
    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send_stream(input bit rand_valid, input int start_at);
        int  sent = 0;
        int  budget = 2000;
        bit  xfer;
        while (sent < stim_q.size() && budget > 0) begin
            in_valid = rand_valid ? 1'($urandom_range(0, 1)) : 1'b1;
            in_data  = stim_q[sent];
            in_last  = (sent == stim_last);
            xfer     = in_valid && (in_ready === 1'b1);
            start    = (sent == start_at) && xfer;
            @(posedge clk); #1;
            if (xfer) sent++;
            budget--;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        start    = 1'b0;
        n_checks++;
        if (budget == 0) begin
            n_fail++;
            $display("FAIL stream_budget: sent %0d of %0d bytes", sent, stim_q.size());
        end
    endtask

    task automatic wait_end();
        int budget = 20;
        while (done !== 1'b1 && error !== 1'b1 && budget > 0) begin
            @(posedge clk); #1;
            budget--;
        end
        repeat (3) begin
            @(posedge clk); #1;
        end
        n_checks++;
        if (budget == 0) begin
            n_fail++;
            $display("FAIL wait_end: done=%0b error=%0b after timeout", done, error);
        end
    endtask

    task automatic compare_writes(input string tag);
        n_checks++;
        if (wr_addr_q.size() !== exp_addr_q.size()) begin
            n_fail++;
            $display("FAIL %s write_count: got %0d expected %0d", tag, wr_addr_q.size(), exp_addr_q.size());
        end else begin
            foreach (exp_addr_q[i]) begin
                n_checks++;
                if (wr_addr_q[i] !== exp_addr_q[i] || wr_data_q[i] !== exp_data_q[i]) begin
                    n_fail++;
                    $display("FAIL %s write[%0d]: got %0d/%08h expected %0d/%08h", tag, i,
                             wr_addr_q[i], wr_data_q[i], exp_addr_q[i], exp_data_q[i]);
                end
            end
        end
        n_checks++;
        if (done !== exp_done || error !== exp_err || cpu_hold !== !exp_done) begin
            n_fail++;
            $display("FAIL %s status: done=%0b error=%0b cpu_hold=%0b expected %0b/%0b/%0b", tag,
                     done, error, cpu_hold, exp_done, exp_err, !exp_done);
        end
        n_checks++;
        if (word_count !== 9'(exp_addr_q.size()) || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL %s count: word_count=%0d in_ready=%0b expected %0d/0", tag,
                     word_count, in_ready, exp_addr_q.size());
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        n_checks++;
        if (in_ready !== 1'b0 || mem_we !== 1'b0 || mem_addr !== 8'd0 || mem_wdata !== 32'd0 ||
            cpu_hold !== 1'b1 || done !== 1'b0 || error !== 1'b0 || word_count !== 9'd0) begin
            n_fail++;
            $display("FAIL reset_state: rdy=%0b we=%0b addr=%0d data=%08h hold=%0b done=%0b err=%0b cnt=%0d expected 0 0 0 0 1 0 0 0",
                     in_ready, mem_we, mem_addr, mem_wdata, cpu_hold, done, error, word_count);
        end
        n_checks++;
        if (s_in_ready !== 1'b0 || s_cpu_hold !== 1'b1 || s_word_count !== 3'd0) begin
            n_fail++;
            $display("FAIL reset_small: rdy=%0b hold=%0b cnt=%0d expected 0 1 0", s_in_ready, s_cpu_hold, s_word_count);
        end
    endtask

    task automatic test_basic();
        stim_q = '{8'h24, 8'h08, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h0C};
        stim_last = 7;
        model_load(256);
        clear_caps();
        pulse_start();
        send_stream(1'b0, -1);
        wait_end();
        compare_writes("basic");
        // Continuous stream: one word every 5 cycles.
        n_checks++;
        if (wr_cyc_q.size() != 2 || wr_cyc_q[1] - wr_cyc_q[0] != 5) begin
            n_fail++;
            $display("FAIL basic_spacing: got %0d writes, spacing %0d expected 2 writes, 5 cycles",
                     wr_cyc_q.size(), (wr_cyc_q.size() == 2) ? wr_cyc_q[1] - wr_cyc_q[0] : -1);
        end
    endtask

    task automatic test_random_valid();
        stim_q.delete();
        for (int i = 0; i < 12; i++) stim_q.push_back(8'($urandom));
        stim_last = 11;
        model_load(256);
        clear_caps();
        pulse_start();
        // A start pulse coinciding with byte 5's transfer must be ignored.
        send_stream(1'b1, 5);
        wait_end();
        compare_writes("random_valid");
    endtask

    task automatic test_bad_last();
        stim_q.delete();
        for (int i = 0; i < 6; i++) stim_q.push_back(8'($urandom));
        stim_last = 5;
        model_load(256);
        clear_caps();
        pulse_start();
        send_stream(1'b1, -1);
        wait_end();
        repeat (5) begin
            @(posedge clk); #1;
        end
        compare_writes("bad_last");
    endtask

    task automatic test_overflow();
        int budget = 200;
        stim_q.delete();
        stim_last = -1;
        clear_caps();
        s_start = 1'b1;
        @(posedge clk); #1;
        s_start = 1'b0;
        while (s_error !== 1'b1 && stim_q.size() < 20 && budget > 0) begin
            s_in_valid = 1'b1;
            s_in_data  = 8'($urandom);
            if (s_in_ready === 1'b1) stim_q.push_back(s_in_data);
            @(posedge clk); #1;
            budget--;
        end
        s_in_valid = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        model_load(4);
        n_checks++;
        if (s_wr_addr_q.size() !== exp_addr_q.size()) begin
            n_fail++;
            $display("FAIL overflow write_count: got %0d expected %0d", s_wr_addr_q.size(), exp_addr_q.size());
        end else begin
            foreach (exp_addr_q[i]) begin
                n_checks++;
                if (s_wr_addr_q[i] !== exp_addr_q[i] || s_wr_data_q[i] !== exp_data_q[i]) begin
                    n_fail++;
                    $display("FAIL overflow write[%0d]: got %0d/%08h expected %0d/%08h", i,
                             s_wr_addr_q[i], s_wr_data_q[i], exp_addr_q[i], exp_data_q[i]);
                end
            end
        end
        n_checks++;
        if (s_error !== exp_err || s_done !== 1'b0 || s_in_ready !== 1'b0 || s_cpu_hold !== 1'b1 ||
            s_word_count !== 3'(exp_addr_q.size())) begin
            n_fail++;
            $display("FAIL overflow status: err=%0b done=%0b rdy=%0b hold=%0b cnt=%0d expected %0b 0 0 1 %0d",
                     s_error, s_done, s_in_ready, s_cpu_hold, s_word_count, exp_err, exp_addr_q.size());
        end
    endtask

    task automatic test_mid_reset();
        stim_q = '{8'($urandom), 8'($urandom)};
        stim_last = -1;
        clear_caps();
        pulse_start();
        send_stream(1'b0, -1);
        rst = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (in_ready !== 1'b0 || mem_we !== 1'b0 || mem_addr !== 8'd0 || mem_wdata !== 32'd0 ||
            cpu_hold !== 1'b1 || done !== 1'b0 || error !== 1'b0 || word_count !== 9'd0) begin
            n_fail++;
            $display("FAIL mid_reset_state: rdy=%0b we=%0b addr=%0d data=%08h hold=%0b done=%0b err=%0b cnt=%0d expected 0 0 0 0 1 0 0 0",
                     in_ready, mem_we, mem_addr, mem_wdata, cpu_hold, done, error, word_count);
        end
        rst = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
        end
        n_checks++;
        if (wr_addr_q.size() != 0) begin
            n_fail++;
            $display("FAIL mid_reset_no_write: got %0d writes expected 0", wr_addr_q.size());
        end
        stim_q.delete();
        for (int i = 0; i < 4; i++) stim_q.push_back(8'($urandom));
        stim_last = 3;
        model_load(256);
        clear_caps();
        pulse_start();
        send_stream(1'b0, -1);
        wait_end();
        compare_writes("after_reset");
    endtask

    task automatic test_restart();
        stim_q = '{8'h08, 8'h00, 8'h00, 8'h00};
        stim_last = 3;
        model_load(256);
        clear_caps();
        pulse_start();
        n_checks++;
        if (done !== 1'b0 || cpu_hold !== 1'b1 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL restart_entry: done=%0b cpu_hold=%0b in_ready=%0b expected 0 1 1", done, cpu_hold, in_ready);
        end
        send_stream(1'b0, -1);
        wait_end();
        compare_writes("restart");
    endtask

    initial begin
        rst = 1'b0;
        start = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = 8'd0;
        s_start = 1'b0; s_in_valid = 1'b0; s_in_last = 1'b0; s_in_data = 8'd0;
        @(posedge clk); #1;
        test_reset();
        test_basic();
        test_random_valid();
        test_bad_last();
        test_overflow();
        test_mid_reset();
        test_restart();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
